// File: rtl/seq_pattern_detector.sv
// Qualified-stream pattern detector: Mealy (y2_out) and Moore (y1_out) match flags, with
// overlapping or non-overlapping detection. Define SEQ_PATTERN_DETECTOR_COUNT_EN to build the
// saturating match counter; otherwise count_out is tied to zero.
module seq_pattern_detector #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [SYM_W-1:0]         sym_in,
  input  logic                     load_in,
  input  logic [SYM_W*SEQ_LEN-1:0] pattern_in,
  input  logic                     overlap_in,
  output logic                     y2_out,
  output logic                     y1_out,
  output logic [CNT_W-1:0]         count_out
);

  localparam int unsigned FillW = $clog2(SEQ_LEN);
  localparam logic [FillW-1:0] FillMax = FillW'(SEQ_LEN - 1);

  // Element k of the pattern is the k-th expected symbol; history element 0 is the oldest.
  logic [SEQ_LEN-1:0][SYM_W-1:0] pattern_q, pattern_d;
  logic [SEQ_LEN-2:0][SYM_W-1:0] hist_q, hist_d;
  logic [FillW-1:0]              fill_q, fill_d;
  logic                          y1_q;

  logic hist_full;
  logic prefix_eq;
  logic last_eq;
  logic match;

  always_comb begin
    hist_full = (fill_q == FillMax);
    prefix_eq = (hist_q == pattern_q[SEQ_LEN-2:0]);
    last_eq   = (sym_in == pattern_q[SEQ_LEN-1]);
    match     = valid_in & ~load_in & ~reset & hist_full & prefix_eq & last_eq;
  end

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (load_in) begin
      pattern_d = pattern_in;
      fill_d    = '0;
    end else if (valid_in) begin
      for (int unsigned i = 0; i < SEQ_LEN - 2; i++) begin
        hist_d[i] = hist_q[i+1];
      end
      hist_d[SEQ_LEN-2] = sym_in;
      // Non-overlapping mode forces a full fresh sequence before the next match.
      if (match && !overlap_in) begin
        fill_d = '0;
      end else if (!hist_full) begin
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      y1_q      <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      y1_q      <= match;
    end
  end

  assign y2_out = match;
  assign y1_out = y1_q;

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_in) begin
      count_d = '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;
`else
  assign count_out = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomised self-checking bench for seq_pattern_detector; a queue-based reference model
// tracks accepted symbols and a second instance (CNT_W=2) exercises counter saturation.
module tb_seq_pattern_detector;

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
  localparam bit CntOn = 1'b1;
`else
  localparam bit CntOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [1:0] sym_in;
  logic       load_in;
  logic [7:0] pattern_in;
  logic       overlap_in;
  logic       y2_out, y1_out, y2_sat, y1_sat;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_pattern_detector #(.SYM_W(2), .SEQ_LEN(4), .CNT_W(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .sym_in     (sym_in),
    .load_in    (load_in),
    .pattern_in (pattern_in),
    .overlap_in (overlap_in),
    .y2_out     (y2_out),
    .y1_out     (y1_out),
    .count_out  (cnt8)
  );

  seq_pattern_detector #(.SYM_W(2), .SEQ_LEN(4), .CNT_W(2)) u_sat (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .sym_in     (sym_in),
    .load_in    (load_in),
    .pattern_in (pattern_in),
    .overlap_in (overlap_in),
    .y2_out     (y2_sat),
    .y1_out     (y1_sat),
    .count_out  (cnt2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pattern symbols, accepted symbols still able to form a match (max 3 kept).
  logic [1:0] m_pat[4];
  logic [1:0] m_q[$];
  int         m_cnt8, m_cnt2;
  bit         m_y1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit model_match();
    if (reset || load_in || !valid_in || m_q.size() < 3) return 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_q[m_q.size() - 3 + k] != m_pat[k]) return 1'b0;
    end
    return sym_in == m_pat[3];
  endfunction

  function automatic int exp_cnt(input int n);
    return CntOn ? n : 0;
  endfunction

  task automatic check_regs();
    check_val("y1", y1_out, m_y1);
    check_val("y1_sat", y1_sat, m_y1);
    check_val("count", cnt8, exp_cnt(m_cnt8));
    check_val("count_sat", cnt2, exp_cnt(m_cnt2));
  endtask

  task automatic step(input bit rst, input bit v, input bit ld, input bit ov,
                      input logic [1:0] s, input logic [7:0] pat);
    bit exp_y2;
    @(negedge clk);
    reset = rst; valid_in = v; load_in = ld; overlap_in = ov; sym_in = s; pattern_in = pat;
    #1;
    exp_y2 = model_match();
    check_val("y2", y2_out, exp_y2);
    check_val("y2_sat", y2_sat, exp_y2);
    check_regs();
    @(posedge clk);
    if (rst) begin
      foreach (m_pat[k]) m_pat[k] = 2'd0;
      m_q.delete();
      m_cnt8 = 0; m_cnt2 = 0; m_y1 = 1'b0;
    end else begin
      m_y1 = exp_y2;
      if (ld) begin
        foreach (m_pat[k]) m_pat[k] = pat[k*2 +: 2];
        m_q.delete();
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (v) begin
        if (exp_y2) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        if (exp_y2 && !ov) m_q.delete();
        else begin
          m_q.push_back(s);
          if (m_q.size() > 3) void'(m_q.pop_front());
        end
      end
    end
  endtask

  task automatic feed(input logic [1:0] s, input bit ov);
    step(1'b0, 1'b1, 1'b0, ov, s, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'(($urandom)), 8'($urandom));
  endtask

  task automatic load(input logic [7:0] pat);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'(($urandom)), pat);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; load_in = 1'b0; overlap_in = 1'b0;
    sym_in = 2'd0; pattern_in = 8'h00;
    m_cnt8 = 0; m_cnt2 = 0; m_y1 = 1'b0;
    foreach (m_pat[k]) m_pat[k] = 2'd0;
    @(posedge clk);

    // Reset held with random inputs, including valid_in=1.
    repeat (2) step(1'b1, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));

    // Basic match 0,1,2,3.
    load(8'hE4);
    feed(2'd0, 1'b1); feed(2'd1, 1'b1); feed(2'd2, 1'b1); feed(2'd3, 1'b1);
    idle();
    check_val("basic_count", cnt8, exp_cnt(1));

    // Overlapping run of 1s.
    load(8'h55);
    repeat (6) feed(2'd1, 1'b1);
    idle();
    check_val("overlap_count", cnt8, exp_cnt(3));

    // Non-overlapping run of 1s.
    load(8'h55);
    repeat (7) feed(2'd1, 1'b0);
    check_val("nonoverlap_count7", cnt8, exp_cnt(1));
    feed(2'd1, 1'b0);
    idle();
    check_val("nonoverlap_count8", cnt8, exp_cnt(2));

    // Gaps do not break a partial sequence, then a reload cancels one.
    load(8'hE4);
    feed(2'd0, 1'b1); idle(); idle(); idle();
    feed(2'd1, 1'b1); feed(2'd2, 1'b1); feed(2'd3, 1'b1);
    feed(2'd0, 1'b1); feed(2'd1, 1'b1); feed(2'd2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'hE4);
    feed(2'd3, 1'b1);
    idle();
    check_val("reload_count", cnt8, 32'd0);

    // Counter saturation on the CNT_W=2 instance.
    load(8'hE4);
    for (int m = 0; m < 5; m++) begin
      feed(2'd0, 1'b0); feed(2'd1, 1'b0); feed(2'd2, 1'b0); feed(2'd3, 1'b0);
    end
    idle();
    check_val("sat_count", cnt2, exp_cnt(3));

    // Reset mid-sequence discards history (and the pattern).
    load(8'hE4);
    feed(2'd0, 1'b1); feed(2'd1, 1'b1); feed(2'd2, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    feed(2'd3, 1'b1);
    load(8'hE4);
    feed(2'd1, 1'b1); feed(2'd2, 1'b1); feed(2'd3, 1'b1);
    idle();

    // Randomised traffic biased toward the loaded pattern.
    for (int c = 0; c < 2000; c++) begin
      int r;
      logic [1:0] s;
      logic [7:0] pats[4];
      pats[0] = 8'hE4; pats[1] = 8'h55; pats[2] = 8'h00; pats[3] = 8'($urandom);
      r = $urandom_range(0, 99);
      s = ($urandom_range(0, 3) != 0) ? m_pat[(m_q.size() < 3) ? m_q.size() : 3] : 2'($urandom);
      if (r < 1) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), s, 8'($urandom));
      else if (r < 3) load(pats[$urandom_range(0, 3)]);
      else step(1'b0, ($urandom_range(0, 4) != 0), 1'b0, 1'($urandom), s, 8'($urandom));
    end
    idle();

    @(negedge clk);
    check_regs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
